vram_scroll_ctrl: RTL and testbench
===================================

VRAM_SCROLL_CTRL -- requirements
Module: vram_scroll_ctrl

Interface
REQ-001 Parameters: ROW_WORDS, default 40, 32-bit VRAM words per text row (2 chars/word); ROWS, default 30, text rows; VRAM words = ROW_WORDS*ROWS = 1200.
REQ-002 CLK  in  1  system clock, 50 MHz, sole clock.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 CMD_VALID  in  1  command request; CMD_READY  out  1  high only in IDLE; a command is accepted on a cycle where both are high.
REQ-005 CMD_OP  in  2  00 nop, 01 clear, 10 scroll-up one row, 11 reserved (accepted, treated as nop).
REQ-006 CMD_FILL  in  16  fill character word {IV,CODE,colour byte}; each write writes {CMD_FILL,CMD_FILL}, latched at acceptance.
REQ-007 HOST_REQ, HOST_WE  in  1 each; HOST_ADDR  in  11; HOST_WDATA  in  32; HOST_BE  in  4  host (Avalon side) access.
REQ-008 HOST_WAITREQ  out  1; HOST_RDVALID  out  1; HOST_RDATA  out  32.
REQ-009 MEM_ADDR  out  11; MEM_RE, MEM_WE  out  1 each; MEM_BE  out  4; MEM_WDATA  out  32; MEM_RDATA  in  32  single VRAM port, fixed 1-cycle read latency.
REQ-010 BUSY  out  1  high whenever state is not IDLE; DONE  out  1  one-cycle completion pulse.

Function
REQ-011 States: IDLE, CLR_WR, SCR_RD, SCR_CAP, SCR_WR, FILL_WR, FIN.
REQ-012 IDLE: on accepting clear -> CLR_WR with idx=0; scroll -> SCR_RD with idx=0; nop/reserved -> FIN.
REQ-013 CLR_WR: per granted cycle, write fill word to idx, idx++; after idx=1199 -> FIN.
REQ-014 SCR_RD: on grant, read idx+ROW_WORDS -> SCR_CAP.
REQ-015 SCR_CAP: no VRAM access; latch MEM_RDATA into hold register -> SCR_WR; port free for host this cycle.
REQ-016 SCR_WR: on grant, write hold to idx, BE=1111, idx++; after idx=(ROWS-1)*ROW_WORDS-1 (1159) -> FILL_WR, else -> SCR_RD.
REQ-017 FILL_WR: per granted cycle, write fill word to idx 1160..1199; after 1199 -> FIN.
REQ-018 FIN: DONE=1 for exactly that cycle -> IDLE.
REQ-019 Engine writes always use BE=1111; idx is 11 bits, never exceeds 1199.
REQ-020 Arbitration: host granted when HOST_REQ=1 unless the fairness rule grants the engine; engine granted otherwise; ungranted engine holds state and idx.
REQ-021 Granted host drives MEM_ADDR/WE/BE/WDATA from HOST_*; MEM_RE=~HOST_WE; HOST_WAITREQ=0.
REQ-022 HOST_WAITREQ=1 exactly when HOST_REQ=1 and the engine is granted.
REQ-023 HOST_RDVALID=1 in the cycle after a granted host read; HOST_RDATA=MEM_RDATA in that cycle. Engine read data is never routed to the host.
REQ-024 Host and engine addressing the same word: no coherence; each granted write lands in its own cycle; a later engine write overwrites.
REQ-025 Host addresses >=1200 pass through unchanged.
REQ-026 MEM_RE=MEM_WE=0 when nothing is granted.

Reset
REQ-027 RESET asserted: state=IDLE, idx=0, hold=0, fairness counter=0, DONE=0, BUSY=0, HOST_RDVALID=0, MEM_WE=MEM_RE=0, effective immediately without a clock edge.
REQ-028 Reset mid-command abandons the command; partial VRAM contents are left as-is; no DONE is issued.

Configuration
REQ-029 Macro VRAM_SCROLL_FAIRNESS_EN defined: a counter counts consecutive host grants while the engine needs the port; at 3, the next cycle grants the engine and the counter clears.
REQ-030 Macro undefined: strict host priority; HOST_WAITREQ is tied 0; the engine may starve.

Verification
REQ-031 Clear, FILL=16'h0720, no host traffic, accept at cycle 0 -> writes 0..1199 of 32'h07200720 on cycles 1..1200; DONE at cycle 1201.
REQ-032 Scroll with word[k]=k, FILL=0 -> word[k]=k+40 for k<1160, word[1160..1199]=0; DONE 3521 cycles after acceptance.
REQ-033 Fairness on, HOST_REQ held 1 during clear -> grant pattern host,host,host,engine repeating; HOST_WAITREQ high on every 4th cycle; clear finishes.
REQ-034 Fairness off, same stimulus -> HOST_WAITREQ never 1; idx frozen until HOST_REQ drops.
REQ-035 Host read of addr 5 in a scroll SCR_CAP cycle -> HOST_RDVALID next cycle with word[5]; engine hold register unaffected.
REQ-036 RESET pulse at idx=600 mid-clear -> BUSY=0 and CMD_READY=1 immediately; words 600..1199 unchanged; no DONE.

Source files
------------

// File: rtl/vram_scroll_ctrl.sv
// Text-mode VRAM engine: full-screen clear and one-row scroll-up, sharing a single VRAM port with a host.
// Optional macro VRAM_SCROLL_FAIRNESS_EN: the engine wins the port after 3 consecutive host grants.
module vram_scroll_ctrl #(
   parameter int ROW_WORDS = 40,
   parameter int ROWS      = 30
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic [1:0]  i_cmd_op,
   input  logic [15:0] i_cmd_fill,
   input  logic        i_host_req,
   input  logic        i_host_we,
   input  logic [10:0] i_host_addr,
   input  logic [31:0] i_host_wdata,
   input  logic [3:0]  i_host_be,
   output logic        o_host_waitreq,
   output logic        o_host_rdvalid,
   output logic [31:0] o_host_rdata,
   output logic [10:0] o_mem_addr,
   output logic        o_mem_re,
   output logic        o_mem_we,
   output logic [3:0]  o_mem_be,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata,
   output logic        o_busy,
   output logic        o_done
);

   localparam logic [10:0] LAST_IDX   = 11'(ROW_WORDS * ROWS - 1);
   localparam logic [10:0] SCROLL_END = 11'((ROWS - 1) * ROW_WORDS - 1);
   localparam logic [10:0] ROW_OFS    = 11'(ROW_WORDS);

   typedef enum logic [2:0] {
      IDLE, CLR_WR, SCR_RD, SCR_CAP, SCR_WR, FILL_WR, FIN
   } state_t;

   state_t      r_state;
   logic [10:0] r_idx;
   logic [31:0] r_hold;
   logic [31:0] r_fill;
   logic        r_done;
   logic        r_busy;
   logic        r_cmd_ready;
   logic        r_host_rdvalid;

   logic        w_eng_need;
   logic        w_host_grant;
   logic        w_eng_grant;
   logic        w_accept;

   // SCR_CAP only samples the read data, so the port is free for the host in that cycle
   assign w_eng_need = (r_state == CLR_WR) || (r_state == SCR_RD) ||
                       (r_state == SCR_WR) || (r_state == FILL_WR);
   assign w_accept   = i_cmd_valid && r_cmd_ready;

`ifdef VRAM_SCROLL_FAIRNESS_EN
   logic [1:0] r_fair_cnt;
   logic       w_force_eng;

   assign w_force_eng    = w_eng_need && (r_fair_cnt == 2'd3);
   assign w_host_grant   = i_host_req && !w_force_eng;
   assign o_host_waitreq = i_host_req && w_force_eng;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_fair_cnt <= 2'd0;
      end else if (w_eng_grant) begin
         r_fair_cnt <= 2'd0;
      end else if (w_host_grant && w_eng_need) begin
         r_fair_cnt <= r_fair_cnt + 2'd1;
      end
   end
`else
   assign w_host_grant   = i_host_req;
   assign o_host_waitreq = 1'b0;
`endif

   assign w_eng_grant = w_eng_need && !w_host_grant;

   // NOTE: every output of this block gets a default first, so no latch is inferred on idle paths.
   always_comb begin
      o_mem_addr  = 11'd0;
      o_mem_re    = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_be    = 4'b0000;
      o_mem_wdata = 32'd0;
      if (w_host_grant) begin
         o_mem_addr  = i_host_addr;
         o_mem_we    = i_host_we;
         o_mem_re    = !i_host_we;
         o_mem_be    = i_host_be;
         o_mem_wdata = i_host_wdata;
      end else if (w_eng_grant) begin
         case (r_state)
            CLR_WR, FILL_WR: begin
               o_mem_addr  = r_idx;
               o_mem_we    = 1'b1;
               o_mem_be    = 4'b1111;
               o_mem_wdata = r_fill;
            end
            SCR_RD: begin
               o_mem_addr = r_idx + ROW_OFS;
               o_mem_re   = 1'b1;
            end
            SCR_WR: begin
               o_mem_addr  = r_idx;
               o_mem_we    = 1'b1;
               o_mem_be    = 4'b1111;
               o_mem_wdata = r_hold;
            end
            default: begin
               o_mem_addr = 11'd0;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_idx       <= 11'd0;
         r_hold      <= 32'd0;
         r_fill      <= 32'd0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_cmd_ready <= 1'b1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_fill      <= {i_cmd_fill, i_cmd_fill};
                  r_idx       <= 11'd0;
                  r_busy      <= 1'b1;
                  r_cmd_ready <= 1'b0;
                  case (i_cmd_op)
                     2'b01:   r_state <= CLR_WR;
                     2'b10:   r_state <= SCR_RD;
                     default: begin
                        r_state <= FIN;
                        r_done  <= 1'b1;
                     end
                  endcase
               end
            end
            CLR_WR, FILL_WR: begin
               if (w_eng_grant) begin
                  if (r_idx == LAST_IDX) begin
                     r_idx   <= 11'd0;
                     r_state <= FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx <= r_idx + 11'd1;
                  end
               end
            end
            SCR_RD: begin
               if (w_eng_grant) begin
                  r_state <= SCR_CAP;
               end
            end
            SCR_CAP: begin
               r_hold  <= i_mem_rdata;
               r_state <= SCR_WR;
            end
            SCR_WR: begin
               if (w_eng_grant) begin
                  r_idx   <= r_idx + 11'd1;
                  r_state <= (r_idx == SCROLL_END) ? FILL_WR : SCR_RD;
               end
            end
            FIN: begin
               r_state     <= IDLE;
               r_busy      <= 1'b0;
               r_cmd_ready <= 1'b1;
            end
            default: begin
               r_state     <= IDLE;
               r_busy      <= 1'b0;
               r_cmd_ready <= 1'b1;
            end
         endcase
      end
   end

   // Only host reads flag valid data; engine reads stay internal
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_host_rdvalid <= 1'b0;
      end else begin
         r_host_rdvalid <= w_host_grant && !i_host_we;
      end
   end

   assign o_host_rdvalid = r_host_rdvalid;
   assign o_host_rdata   = i_mem_rdata;
   assign o_cmd_ready    = r_cmd_ready;
   assign o_busy         = r_busy;
   assign o_done         = r_done;

endmodule

// File: tb/tb_vram_scroll_ctrl.sv
// Self-checking bench for vram_scroll_ctrl: command table, corner-case sequences and
// randomized host traffic checked against a word-array model of the screen.
module tb_vram_scroll_ctrl;

   localparam int RW = 40;
   localparam int NR = 30;
   localparam int NW = RW * NR;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_fill;
   logic        host_req;
   logic        host_we;
   logic [10:0] host_addr;
   logic [31:0] host_wdata;
   logic [3:0]  host_be;
   logic        host_waitreq;
   logic        host_rdvalid;
   logic [31:0] host_rdata;
   logic [10:0] mem_addr;
   logic        mem_re;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        done;

   logic [31:0] vram    [0:2047];
   logic [31:0] exp_mem [0:2047];

   int n_checks = 0;
   int n_errors = 0;

   // random-traffic state
   bit          hold_req = 1'b0;
   bit          pend_rd  = 1'b0;
   logic [31:0] pend_data;
   int          spur = 0;
   int          waits = 0;

   always #5 clk = ~clk;

   vram_scroll_ctrl #(.ROW_WORDS(RW), .ROWS(NR)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_op(cmd_op), .i_cmd_fill(cmd_fill),
      .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr),
      .i_host_wdata(host_wdata), .i_host_be(host_be),
      .o_host_waitreq(host_waitreq), .o_host_rdvalid(host_rdvalid), .o_host_rdata(host_rdata),
      .o_mem_addr(mem_addr), .o_mem_re(mem_re), .o_mem_we(mem_we),
      .o_mem_be(mem_be), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
      .o_busy(busy), .o_done(done)
   );

   // VRAM: byte-enabled writes, 1-cycle read latency
   always @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) vram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      if (mem_re) mem_rdata <= vram[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // screen model: a command's effect described directly on the word array
   task automatic apply_model(input logic [1:0] op, input logic [15:0] fill);
      if (op == 2'b01) begin
         for (int k = 0; k < NW; k++) exp_mem[k] = {fill, fill};
      end else if (op == 2'b10) begin
         for (int k = 0; k < NW - RW; k++) exp_mem[k] = exp_mem[k + RW];
         for (int k = NW - RW; k < NW; k++) exp_mem[k] = {fill, fill};
      end
   endtask

   task automatic host_wr(input int a, input logic [31:0] d);
      @(negedge clk);
      host_req = 1'b1; host_we = 1'b1; host_addr = 11'(a); host_wdata = d; host_be = 4'hF;
      exp_mem[a] = d;
   endtask

   task automatic host_idle();
      @(negedge clk);
      host_req = 1'b0; host_we = 1'b0;
   endtask

   task automatic preload(input bit idx_pat);
      for (int a = 0; a < NW; a++) host_wr(a, idx_pat ? 32'(a) : $urandom);
      host_idle();
   endtask

   task automatic read_range(input string name, input int lo, input int hi);
      int mism = 0;
      for (int a = lo; a <= hi + 1; a++) begin
         @(negedge clk);
         if (a <= hi) begin
            host_req = 1'b1; host_we = 1'b0; host_addr = 11'(a);
         end else begin
            host_req = 1'b0;
         end
         #1;
         if (a > lo && (!host_rdvalid || host_rdata !== exp_mem[a - 1])) mism++;
      end
      check(name, 32'(mism), 32'd0);
   endtask

   task automatic issue_cmd(input logic [1:0] op, input logic [15:0] fill);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_fill = fill; host_req = 1'b0;
      #1;
      check("cmd_ready_at_accept", 32'(cmd_ready), 32'd1);
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [15:0] fill,
                          output int done_c, output int wr, output int rd,
                          output int first, output int last, output int busy1);
      done_c = -1; wr = 0; rd = 0; first = -1; last = -1; busy1 = 0;
      issue_cmd(op, fill);
      for (int c = 1; c <= 6000 && done_c < 0; c++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         #1;
         if (c == 1) busy1 = int'(busy);
         if (mem_we) begin
            wr++;
            if (first < 0) first = c;
            last = c;
         end
         if (mem_re) rd++;
         if (done) done_c = c;
      end
      @(negedge clk);
      #1;
      check("done_single_pulse", 32'(done), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
      check("ready_after_done", 32'(cmd_ready), 32'd1);
   endtask

   // one cycle of random host traffic; a stalled request is held unchanged until granted
   task automatic rand_host_cycle(input bit enable, input int lo, output bit granted);
      granted = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      if (!hold_req) begin
         if (enable && $urandom_range(0, 2) == 0) begin
            host_req   = 1'b1;
            host_we    = 1'($urandom_range(0, 1));
            host_addr  = 11'($urandom_range(lo, 2047));
            host_wdata = $urandom;
            host_be    = 4'($urandom_range(1, 15));
         end else begin
            host_req = 1'b0;
         end
      end
      #1;
      if (pend_rd) begin
         check("rand_rdvalid", 32'(host_rdvalid), 32'd1);
         check("rand_rdata", host_rdata, pend_data);
      end else if (host_rdvalid) begin
         spur++;
      end
      pend_rd = 1'b0;
      if (host_req) begin
         if (host_waitreq) begin
            waits++;
            hold_req = 1'b1;
         end else begin
            granted  = 1'b1;
            hold_req = 1'b0;
            if (host_we) begin
               for (int b = 0; b < 4; b++)
                  if (host_be[b]) exp_mem[host_addr][8*b +: 8] = host_wdata[8*b +: 8];
            end else begin
               pend_rd   = 1'b1;
               pend_data = exp_mem[host_addr];
            end
         end
      end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [15:0] fill;
      bit          idx_pat;
      int          done_c;
      int          wr;
      int          rd;
      int          first;
      int          last;
   } vec_t;

   initial begin
      vec_t vecs [5];
      int   done_c, wr, rd, first, last, busy1, bad, g;
      bit   gr;
      logic [15:0] rfill;

      vecs[0] = '{2'b00, 16'h1234, 1'b0, 1,    0,    0,    -1, -1};
      vecs[1] = '{2'b11, 16'h4321, 1'b0, 1,    0,    0,    -1, -1};
      vecs[2] = '{2'b01, 16'h0720, 1'b0, 1201, 1200, 0,    1,  1200};
      vecs[3] = '{2'b10, 16'h0000, 1'b1, 3521, 1200, 1160, 3,  3520};
      vecs[4] = '{2'b10, 16'hA5C3, 1'b0, 3521, 1200, 1160, 3,  3520};

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_fill = 16'h0;
      host_req = 1'b0; host_we = 1'b0; host_addr = 11'd0; host_wdata = 32'd0; host_be = 4'h0;
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_ready", 32'(cmd_ready), 32'd1);
      check("reset_done", 32'(done), 32'd0);
      check("reset_rdvalid", 32'(host_rdvalid), 32'd0);
      check("reset_mem_we", 32'(mem_we), 32'd0);
      check("reset_mem_re", 32'(mem_re), 32'd0);
      check("reset_waitreq", 32'(host_waitreq), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int a = NW; a < 2048; a++) host_wr(a, $urandom);
      host_idle();

      // command table
      for (int i = 0; i < 5; i++) begin
         preload(vecs[i].idx_pat);
         run_cmd(vecs[i].op, vecs[i].fill, done_c, wr, rd, first, last, busy1);
         check($sformatf("v%0d_done_cycle", i), 32'(done_c), 32'(vecs[i].done_c));
         check($sformatf("v%0d_busy_cycle1", i), 32'(busy1), 32'd1);
         check($sformatf("v%0d_writes", i), 32'(wr), 32'(vecs[i].wr));
         check($sformatf("v%0d_reads", i), 32'(rd), 32'(vecs[i].rd));
         check($sformatf("v%0d_first_wr", i), 32'(first), 32'(vecs[i].first));
         check($sformatf("v%0d_last_wr", i), 32'(last), 32'(vecs[i].last));
         apply_model(vecs[i].op, vecs[i].fill);
         read_range($sformatf("v%0d_contents", i), 0, NW - 1);
      end

      // host read of word 5 in the first SCR_CAP cycle of a scroll
      preload(1'b1);
      issue_cmd(2'b10, 16'h0000);
      @(negedge clk); cmd_valid = 1'b0; #1;
      @(negedge clk); host_req = 1'b1; host_we = 1'b0; host_addr = 11'd5; #1;
      check("cap_host_mem_re", 32'(mem_re), 32'd1);
      check("cap_host_mem_addr", 32'(mem_addr), 32'd5);
      @(negedge clk); host_req = 1'b0; #1;
      check("cap_host_rdvalid", 32'(host_rdvalid), 32'd1);
      check("cap_host_rdata", host_rdata, 32'd5);
      done_c = -1;
      for (int c = 4; c <= 6000 && done_c < 0; c++) begin
         @(negedge clk); #1;
         if (c == 4) check("cap_rdvalid_one_cycle", 32'(host_rdvalid), 32'd0);
         if (done) done_c = c;
      end
      check("cap_done_cycle", 32'(done_c), 32'd3521);
      apply_model(2'b10, 16'h0000);
      read_range("cap_contents", 0, NW - 1);

`ifdef VRAM_SCROLL_FAIRNESS_EN
      // host held on the port during a clear: engine gets every 4th cycle
      issue_cmd(2'b01, 16'h5A5A);
      bad = 0; done_c = -1;
      for (int c = 1; c <= 6000 && done_c < 0; c++) begin
         @(negedge clk);
         cmd_valid = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 11'd1300;
         #1;
         if (c <= 4800 && host_waitreq !== ((c % 4) == 0)) bad++;
         if (done) done_c = c;
      end
      host_idle();
      check("fair_waitreq_pattern", 32'(bad), 32'd0);
      check("fair_done_cycle", 32'(done_c), 32'd4801);
      apply_model(2'b01, 16'h5A5A);
      read_range("fair_contents", 0, NW - 1);
`else
      // strict host priority: engine frozen while the host holds the port
      issue_cmd(2'b01, 16'hBEEF);
      bad = 0;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         cmd_valid = 1'b0; host_req = 1'b1; host_we = 1'b1; host_addr = 11'd1500;
         host_wdata = 32'(c); host_be = 4'hF;
         #1;
         if (host_waitreq) bad++;
         if (mem_we && mem_addr < 11'(NW)) bad++;
      end
      exp_mem[1500] = 32'd50;
      check("strict_no_wait_engine_frozen", 32'(bad), 32'd0);
      @(negedge clk); host_req = 1'b0; #1;
      check("strict_resume_we", 32'(mem_we), 32'd1);
      check("strict_resume_addr", 32'(mem_addr), 32'd0);
      done_c = -1;
      for (int c = 52; c <= 6000 && done_c < 0; c++) begin
         @(negedge clk); #1;
         if (done) done_c = c;
      end
      check("strict_done_cycle", 32'(done_c), 32'd1251);
      apply_model(2'b01, 16'hBEEF);
      read_range("strict_contents", 0, NW - 1);
`endif

      // reset in the middle of a clear, at idx 600
      preload(1'b1);
      issue_cmd(2'b01, 16'h1111);
      bad = 0;
      for (int c = 1; c <= 600; c++) begin
         @(negedge clk); cmd_valid = 1'b0; #1;
         if (done) bad++;
      end
      @(negedge clk); #1;
      check("pre_reset_addr", 32'(mem_addr), 32'd600);
      rst = 1'b1;
      #1;
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_ready", 32'(cmd_ready), 32'd1);
      check("midreset_mem_we", 32'(mem_we), 32'd0);
      repeat (2) begin
         @(negedge clk);
         if (done) bad++;
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk); #1;
         if (done || busy) bad++;
      end
      check("midreset_no_done", 32'(bad), 32'd0);
      for (int k = 0; k < 600; k++) exp_mem[k] = 32'h11111111;
      read_range("midreset_contents", 0, NW - 1);

      // randomized host traffic during a clear (upper, off-screen words only)
      rfill = 16'($urandom);
      issue_cmd(2'b01, rfill);
      g = 0; done_c = -1; waits = 0;
      for (int c = 1; c <= 8000 && done_c < 0; c++) begin
         rand_host_cycle(c <= 400, NW, gr);
         if (gr && !done) g++;
         if (done) done_c = c;
      end
      repeat (4) rand_host_cycle(1'b0, NW, gr);
      check("rand_clear_done_cycle", 32'(done_c), 32'(1201 + g));
`ifndef VRAM_SCROLL_FAIRNESS_EN
      check("rand_clear_no_wait", 32'(waits), 32'd0);
`endif
      apply_model(2'b01, rfill);

      // randomized host traffic with the engine idle, any address
      for (int c = 0; c < 300; c++) rand_host_cycle(1'b1, 0, gr);
      repeat (4) rand_host_cycle(1'b0, 0, gr);
      check("no_spurious_rdvalid", 32'(spur), 32'd0);
      read_range("final_contents", 0, 2047);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
